// File: rtl/uart_1553_word_packer.sv
// uart_1553_word_packer
// Packs 3-byte UART frames (cmd, data_hi, data_lo) into one 16-bit 1553 data
// word with the command byte carried on m_axis_tuser. A partial frame that
// sits idle for TIMEOUT_CYCLES cycles is dropped and flagged on timeout_err.
//
// Handshake rule on both ports: a transfer happens on a rising aclk edge
// where tvalid and tready are both high. A master holds tvalid and tdata
// stable until that transfer. The input side is never ready while a packed
// word waits on the output.
module uart_1553_word_packer #(
  parameter int CLOCK_SPEED    = 12000000,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        timeout_err,
  output logic        busy
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_HI = 2'd1,
    GET_LO = 2'd2,
    SEND   = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    cmd_q;
  logic [7:0]    hi_q;
  logic [15:0]   tdata_q;
  logic [7:0]    tuser_q;
  logic          tvalid_q;
  logic          s_ready_q;
  logic          timeout_q;
  logic          busy_q;

  logic          in_hs;
  logic          out_hs;
  logic          cnt_last;

  // Handshake and timeout-expiry qualifiers for the current cycle.
  always_comb begin
    in_hs    = s_axis_tvalid & s_ready_q;
    out_hs   = tvalid_q & m_axis_tready;
    cnt_last = (cnt_q == CNT_LAST);
  end

  // Frame assembly FSM; every output is a register updated alongside the state.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      hi_q      <= '0;
      tdata_q   <= '0;
      tuser_q   <= '0;
      tvalid_q  <= 1'b0;
      s_ready_q <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      s_ready_q <= 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (in_hs) begin
            cmd_q   <= s_axis_tdata;
            state_q <= GET_HI;
            busy_q  <= 1'b1;
          end
        end
        GET_HI: begin
          if (in_hs) begin
            hi_q    <= s_axis_tdata;
            cnt_q   <= '0;
            state_q <= GET_LO;
          end else if (cnt_last) begin
            cnt_q     <= '0;
            state_q   <= IDLE;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GET_LO: begin
          if (in_hs) begin
            tdata_q   <= {hi_q, s_axis_tdata};
            tuser_q   <= cmd_q;
            tvalid_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= SEND;
            s_ready_q <= 1'b0;
          end else if (cnt_last) begin
            cnt_q     <= '0;
            state_q   <= IDLE;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SEND: begin
          // No timeout here: downstream may stall for as long as it likes.
          cnt_q <= '0;
          if (out_hs) begin
            tvalid_q <= 1'b0;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end else begin
            s_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign timeout_err   = timeout_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_1553_word_packer.sv
// Directed bench for uart_1553_word_packer with TIMEOUT_CYCLES = 16.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_uart_1553_word_packer;

  localparam int TO = 16;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic [7:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        timeout_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_rx  = 0;
  bit mon_en = 1'b0;
  bit rand_en = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;

  uart_1553_word_packer #(.CLOCK_SPEED(12000000), .TIMEOUT_CYCLES(TO)) dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  // Clock and reset block
  always #5 aclk = ~aclk;

  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_reset();
    arstn = 1'b0;
    cycle();
    arstn = 1'b1;
  endtask

  // Driver: offer one byte and return 1 unit after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    if (rand_en) m_tready = 1'($urandom_range(0, 1));
    while (s_tready !== 1'b1 && waited < 1000) begin
      cycle();
      if (rand_en) m_tready = 1'($urandom_range(0, 1));
      waited++;
    end
    n_cmp++;
    if (waited >= 1000) begin
      n_err++;
      $display("FAIL send_byte_wait: byte %h never accepted, s_axis_tready=%b required 1", b, s_tready);
    end else begin
      cycle();
    end
    s_tvalid = 1'b0;
  endtask

  // Scoreboard: every output handshake must match the oldest queued frame.
  always @(negedge aclk) begin
    if (mon_en && m_tvalid === 1'b1 && m_tready === 1'b1) begin
      n_cmp++;
      n_rx++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL stream_extra: got {tuser,tdata}=%h with nothing expected", {m_tuser, m_tdata});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({m_tuser, m_tdata} !== mon_exp) begin
          n_err++;
          $display("FAIL stream_word: got %h required %h", {m_tuser, m_tdata}, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    arstn = 1'b0;
    repeat (3) cycle();
    n_cmp++;
    if ({s_tready, m_tvalid, timeout_err, busy} !== 4'b0000 || m_tdata !== 16'h0 || m_tuser !== 8'h0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b vld=%b to=%b busy=%b tdata=%h tuser=%h required all 0",
               s_tready, m_tvalid, timeout_err, busy, m_tdata, m_tuser);
    end
    arstn = 1'b1;
    cycle();
    n_cmp++;
    if (s_tready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: s_axis_tready=%b busy=%b required 1 0", s_tready, busy);
    end
  endtask

  task automatic test_normal();
    m_tready = 1'b1;
    send_byte(8'hA5);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL normal_busy: busy=%b required 1", busy);
    end
    send_byte(8'h12);
    send_byte(8'h34);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h1234 || m_tuser !== 8'hA5 || s_tready !== 1'b0) begin
      n_err++;
      $display("FAIL normal_word: vld=%b tdata=%h tuser=%h rdy=%b required 1 1234 a5 0",
               m_tvalid, m_tdata, m_tuser, s_tready);
    end
    cycle();
    n_cmp++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL normal_after: vld=%b busy=%b rdy=%b required 0 0 1", m_tvalid, busy, s_tready);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    m_tready = 1'b0;
    send_byte(8'h01);
    send_byte(8'hBE);
    send_byte(8'hEF);
    s_tdata  = 8'h55;
    s_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_tvalid !== 1'b1 || m_tdata !== 16'hBEEF || m_tuser !== 8'h01 || s_tready !== 1'b0) bad++;
      cycle();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bp_hold: %0d of 20 cycles unstable (vld=%b tdata=%h tuser=%h rdy=%b) required 0",
               bad, m_tvalid, m_tdata, m_tuser, s_tready);
    end
    m_tready = 1'b1;
    cycle();
    n_cmp++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: vld=%b busy=%b rdy=%b required 0 0 1", m_tvalid, busy, s_tready);
    end
    cycle();
    s_tvalid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL bp_fourth_byte: busy=%b required 1", busy);
    end
    send_byte(8'h66);
    send_byte(8'h77);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h6677 || m_tuser !== 8'h55) begin
      n_err++;
      $display("FAIL bp_next_word: vld=%b tdata=%h tuser=%h required 1 6677 55", m_tvalid, m_tdata, m_tuser);
    end
    cycle();
  endtask

  task automatic test_timeout();
    int early = 0;
    send_byte(8'h07);
    for (int i = 0; i < TO - 1; i++) begin
      cycle();
      if (timeout_err !== 1'b0 || busy !== 1'b1) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_err++;
      $display("FAIL timeout_early: %0d bad cycles before expiry required 0", early);
    end
    cycle();
    n_cmp++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_pulse: to=%b busy=%b rdy=%b required 1 0 1", timeout_err, busy, s_tready);
    end
    cycle();
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_width: timeout_err=%b required 0", timeout_err);
    end
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h0001 || m_tuser !== 8'h02) begin
      n_err++;
      $display("FAIL timeout_recover: vld=%b tdata=%h tuser=%h required 1 0001 02", m_tvalid, m_tdata, m_tuser);
    end
    cycle();
  endtask

  task automatic test_timeout_boundary();
    int seen = 0;
    send_byte(8'h11);
    for (int i = 0; i < TO - 1; i++) begin
      cycle();
      if (timeout_err !== 1'b0) seen++;
    end
    send_byte(8'h22);
    if (timeout_err !== 1'b0) seen++;
    send_byte(8'h33);
    n_cmp++;
    if (seen != 0 || m_tvalid !== 1'b1 || m_tdata !== 16'h2233 || m_tuser !== 8'h11) begin
      n_err++;
      $display("FAIL boundary_15: to_seen=%0d vld=%b tdata=%h tuser=%h required 0 1 2233 11",
               seen, m_tvalid, m_tdata, m_tuser);
    end
    cycle();
    // 16-cycle gap while waiting for the low byte; output registers keep the last word.
    send_byte(8'h44);
    send_byte(8'h55);
    repeat (TO) cycle();
    n_cmp++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== 16'h2233 || m_tuser !== 8'h11) begin
      n_err++;
      $display("FAIL boundary_16: to=%b busy=%b vld=%b tdata=%h tuser=%h required 1 0 0 2233 11",
               timeout_err, busy, m_tvalid, m_tdata, m_tuser);
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    m_tready = 1'b1;
    send_byte(8'h81);
    send_byte(8'h82);
    pulse_reset();
    cycle();
    n_cmp++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0 || timeout_err !== 1'b0 || s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_frame: busy=%b vld=%b to=%b rdy=%b required 0 0 0 1", busy, m_tvalid, timeout_err, s_tready);
    end
    send_byte(8'h83);
    send_byte(8'h84);
    send_byte(8'h85);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h8485 || m_tuser !== 8'h83) begin
      n_err++;
      $display("FAIL reset_mid_next: vld=%b tdata=%h tuser=%h required 1 8485 83", m_tvalid, m_tdata, m_tuser);
    end
    cycle();
    m_tready = 1'b0;
    send_byte(8'h91);
    send_byte(8'h92);
    send_byte(8'h93);
    arstn = 1'b0;
    cycle();
    n_cmp++;
    if (m_tvalid !== 1'b0 || m_tdata !== 16'h0 || m_tuser !== 8'h0 || busy !== 1'b0 || s_tready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_send: vld=%b tdata=%h tuser=%h busy=%b rdy=%b required 0 0000 00 0 0",
               m_tvalid, m_tdata, m_tuser, busy, s_tready);
    end
    arstn = 1'b1;
    for (int i = 0; i < TO + 4; i++) begin
      cycle();
      if (timeout_err !== 1'b0 || m_tvalid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_quiet: %0d cycles with timeout_err or tvalid set, required 0", seen);
    end
    m_tready = 1'b1;
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'hA2A3 || m_tuser !== 8'hA1) begin
      n_err++;
      $display("FAIL reset_send_next: vld=%b tdata=%h tuser=%h required 1 a2a3 a1", m_tvalid, m_tdata, m_tuser);
    end
    cycle();
  endtask

  task automatic test_streaming();
    logic [23:0] frames [8];
    int guard = 0;
    frames[0] = 24'h00FFFF; frames[1] = 24'hFF0000;
    frames[2] = 24'h10A55A; frames[3] = 24'h201234;
    frames[4] = 24'h308001; frames[5] = 24'h407FFE;
    frames[6] = 24'h50DEAD; frames[7] = 24'h60C0DE;
    n_rx    = 0;
    mon_en  = 1'b1;
    rand_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      exp_q.push_back(frames[f]);
      send_byte(frames[f][23:16]);
      send_byte(frames[f][15:8]);
      send_byte(frames[f][7:0]);
    end
    while (exp_q.size() != 0 && guard < 200) begin
      m_tready = 1'($urandom_range(0, 1));
      cycle();
      guard++;
    end
    rand_en  = 1'b0;
    m_tready = 1'b1;
    repeat (3) cycle();
    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || n_rx != 8) begin
      n_err++;
      $display("FAIL stream_count: received %0d words, %0d pending, required 8 and 0", n_rx, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_streaming();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
